cam_capture: RTL



---
 rtl/cam_capture_if.sv | 25 ++
 rtl/cam_capture.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cam_capture_if.sv
// Capture-side bundle: sampled camera pins in, frame-buffer write port and event pulses out.
// The master modport belongs to cam_capture; the slave modport is the camera/frame-buffer side.
interface cam_capture_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              cam_pclk;
    logic              cam_vref;
    logic              cam_href;
    logic [7:0]        cam_data;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              frame_done;
    logic              line_err;

    modport master (
        input  cam_pclk, cam_vref, cam_href, cam_data,
        output we, wr_addr, wr_data, frame_done, line_err
    );

    modport slave (
        output cam_pclk, cam_vref, cam_href, cam_data,
        input  we, wr_addr, wr_data, frame_done, line_err
    );
endinterface

// File: rtl/cam_capture.sv
// OV7670-style camera capture: RGB565 byte pairs to RGB444 frame-buffer writes with frame/line flags.
// Optional 2:1 decimation on both axes when CAM_CAPTURE_DECIMATE_EN is defined.
module cam_capture #(
    parameter int unsigned H_PIXELS = 320,
    parameter int unsigned V_LINES  = 240,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic          clk,
    input  logic          reset,
    cam_capture_if.master bus
);

    typedef enum logic [2:0] {StSync, StVblank, StLine, StHi, StLo} state_e;

    state_e            state_q;
    logic [10:0]       sync1_q, sync2_q;
    logic              pclk_q;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] col_q, line_q, line_base_q;
    logic              we_q, frame_done_q, line_err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [11:0]       wr_data_q;

    logic              s_pclk, s_vref, s_href;
    logic [7:0]        s_data;
    logic              strobe, pix_done, line_end, frame_end;
    logic              col_ok, line_ok, keep_pix, keep_line;
    logic [11:0]       pix_d;

    assign {s_pclk, s_vref, s_href, s_data} = sync2_q;

    always_comb begin
        strobe    = s_pclk & ~pclk_q;
        frame_end = strobe & s_vref &
                    ((state_q == StLine) | (state_q == StHi) | (state_q == StLo));
        line_end  = strobe & ~s_vref & ~s_href & ((state_q == StHi) | (state_q == StLo));
        pix_done  = strobe & ~s_vref & s_href & (state_q == StLo);
        col_ok    = col_q < ADDR_W'(H_PIXELS);
        line_ok   = line_q < ADDR_W'(V_LINES);
        pix_d     = {hi_q[7:4], hi_q[2:0], s_data[7], s_data[4:1]};
    end

`ifdef CAM_CAPTURE_DECIMATE_EN
    // Raw column/line parity; only even/even raw pixels reach the stored counters.
    logic col_odd_q, line_odd_q;

    always_ff @(posedge clk) begin
        if (reset || frame_end) begin
            col_odd_q  <= 1'b0;
            line_odd_q <= 1'b0;
        end else if (line_end) begin
            col_odd_q  <= 1'b0;
            line_odd_q <= ~line_odd_q;
        end else if (pix_done) begin
            col_odd_q  <= ~col_odd_q;
        end
    end

    assign keep_pix  = ~col_odd_q & ~line_odd_q;
    assign keep_line = ~line_odd_q;
`else
    assign keep_pix  = 1'b1;
    assign keep_line = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            pclk_q       <= 1'b0;
            state_q      <= StSync;
            hi_q         <= '0;
            col_q        <= '0;
            line_q       <= '0;
            line_base_q  <= '0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            sync1_q      <= {bus.cam_pclk, bus.cam_vref, bus.cam_href, bus.cam_data};
            sync2_q      <= sync1_q;
            pclk_q       <= s_pclk;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            // Event priority: frame end beats line end, so a joint edge never flags line_err.
            if (frame_end) begin
                frame_done_q <= 1'b1;
                col_q        <= '0;
                line_q       <= '0;
                line_base_q  <= '0;
                state_q      <= StVblank;
            end else if (line_end) begin
                line_err_q <= (state_q == StLo);
                col_q      <= '0;
                if (keep_line && line_ok) begin
                    line_q      <= line_q + 1'b1;
                    line_base_q <= line_base_q + ADDR_W'(H_PIXELS);
                end
                state_q <= StLine;
            end else if (pix_done) begin
                if (keep_pix && col_ok && line_ok) begin
                    we_q      <= 1'b1;
                    wr_addr_q <= line_base_q + col_q;
                    wr_data_q <= pix_d;
                end
                if (keep_pix && col_ok) col_q <= col_q + 1'b1;
                state_q <= StHi;
            end else if (strobe) begin
                unique case (state_q)
                    StSync:   if (s_vref) state_q <= StVblank;
                    StVblank: if (!s_vref) state_q <= StLine;
                    StLine: begin
                        if (s_href) begin
                            hi_q    <= s_data;
                            state_q <= StLo;
                        end
                    end
                    StHi: begin
                        hi_q    <= s_data;
                        state_q <= StLo;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.we         = we_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.line_err   = line_err_q;

endmodule
